// File: rtl/hue_pwm_engine.sv
// hue_pwm_engine: multi-LED hue-wheel PWM driver with brightness scaling and evenly spaced hue offsets.
// Define HUE_PWM_INVERT_EN for active-low (common-anode) pwm_r/g/b outputs.
module hue_pwm_engine #(
    parameter int PWM_INTERVAL = 1200,
    parameter int STEP_PERIODS = 100,
    parameter int HUE_STEPS    = 360,
    parameter int NUM_LEDS     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         step_req,
    input  logic [7:0]                   brightness,
    output logic [NUM_LEDS-1:0]          pwm_r,
    output logic [NUM_LEDS-1:0]          pwm_g,
    output logic [NUM_LEDS-1:0]          pwm_b,
    output logic [$clog2(HUE_STEPS)-1:0] hue,
    output logic                         period_start,
    output logic                         wrap
);
    localparam int CW  = $clog2(PWM_INTERVAL);
    localparam int SW  = STEP_PERIODS > 1 ? $clog2(STEP_PERIODS) : 1;
    localparam int HW  = $clog2(HUE_STEPS);
    localparam int DW  = $clog2(PWM_INTERVAL + 1);
    localparam int S   = HUE_STEPS / 6;
    localparam int OFF = HUE_STEPS / NUM_LEDS;
`ifdef HUE_PWM_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic [CW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [HW-1:0] hue_q, hue_d;
    logic pend_q, pend_d, first_q, first_d, ps_q, ps_d, wrap_q, wrap_d;
    logic [NUM_LEDS-1:0][DW-1:0] dr_q, dr_d, dg_q, dg_d, db_q, db_d;
    logic [NUM_LEDS-1:0] pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
    logic p_end, s_end, bnd, manual, req, fwd_wrap, rev_wrap, inc, dec, latch;
    logic [3*DW-1:0] col;

    // {R,G,B} full-brightness duty for one hue position
    function automatic logic [3*DW-1:0] rgb(input int h);
        int up, dn;
        up = (h % S) * PWM_INTERVAL / S;
        dn = PWM_INTERVAL - up;
        case (h / S)
            0:       return {DW'(PWM_INTERVAL), DW'(up), DW'(0)};
            1:       return {DW'(dn), DW'(PWM_INTERVAL), DW'(0)};
            2:       return {DW'(0), DW'(PWM_INTERVAL), DW'(up)};
            3:       return {DW'(0), DW'(dn), DW'(PWM_INTERVAL)};
            4:       return {DW'(up), DW'(0), DW'(PWM_INTERVAL)};
            default: return {DW'(PWM_INTERVAL), DW'(0), DW'(dn)};
        endcase
    endfunction

    function automatic logic [DW-1:0] scale(input logic [DW-1:0] d, input logic [7:0] b);
        logic [DW+8:0] p;
        p = {9'd0, d} * {{DW{1'b0}}, {1'b0, b} + 9'd1};
        return (b == 8'd0) ? '0 : DW'(p >> 8);
    endfunction

    always_comb begin
        p_end      = pwm_cnt_q == CW'(PWM_INTERVAL - 1);
        s_end      = step_cnt_q == SW'(STEP_PERIODS - 1);
        bnd        = en & p_end & s_end;
        latch      = en & p_end;
        manual     = mode == 2'd3;
        req        = pend_q | (manual & step_req);
        fwd_wrap   = hue_q == HW'(HUE_STEPS - 1);
        rev_wrap   = hue_q == '0;
        inc        = bnd & ((mode == 2'd0) | (manual & req));
        dec        = bnd & (mode == 2'd1);
        hue_d      = inc ? (fwd_wrap ? '0 : hue_q + 1'b1) :
                     dec ? (rev_wrap ? HW'(HUE_STEPS - 1) : hue_q - 1'b1) : hue_q;
        wrap_d     = (inc & fwd_wrap) | (dec & rev_wrap);
        pwm_cnt_d  = !en ? pwm_cnt_q : p_end ? '0 : pwm_cnt_q + 1'b1;
        step_cnt_d = !latch ? step_cnt_q : s_end ? '0 : step_cnt_q + 1'b1;
        pend_d     = !en ? pend_q : bnd ? 1'b0 : req;
        ps_d       = en & (p_end | first_q);
        first_d    = first_q & ~en;
        col        = '0;
        dr_d       = dr_q;
        dg_d       = dg_q;
        db_d       = db_q;
        pr_d       = '0;
        pg_d       = '0;
        pb_d       = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            col = rgb((int'(hue_d) + i * OFF) % HUE_STEPS);
            if (latch) begin
                dr_d[i] = scale(col[3*DW-1:2*DW], brightness);
                dg_d[i] = scale(col[2*DW-1:DW], brightness);
                db_d[i] = scale(col[DW-1:0], brightness);
            end
            pr_d[i] = INV ^ (en & (DW'(pwm_cnt_q) < dr_q[i]));
            pg_d[i] = INV ^ (en & (DW'(pwm_cnt_q) < dg_q[i]));
            pb_d[i] = INV ^ (en & (DW'(pwm_cnt_q) < db_q[i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            hue_q      <= '0;
            pend_q     <= 1'b0;
            first_q    <= 1'b1;
            ps_q       <= 1'b0;
            wrap_q     <= 1'b0;
            dr_q       <= '0;
            dg_q       <= '0;
            db_q       <= '0;
            pr_q       <= {NUM_LEDS{INV}};
            pg_q       <= {NUM_LEDS{INV}};
            pb_q       <= {NUM_LEDS{INV}};
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            hue_q      <= hue_d;
            pend_q     <= pend_d;
            first_q    <= first_d;
            ps_q       <= ps_d;
            wrap_q     <= wrap_d;
            dr_q       <= dr_d;
            dg_q       <= dg_d;
            db_q       <= db_d;
            pr_q       <= pr_d;
            pg_q       <= pg_d;
            pb_q       <= pb_d;
        end
    end

    assign pwm_r        = pr_q;
    assign pwm_g        = pg_q;
    assign pwm_b        = pb_q;
    assign hue          = hue_q;
    assign period_start = ps_q;
    assign wrap         = wrap_q;
endmodule

// File: doc/hue_pwm_engine.md
Name: hue_pwm_engine

Overview:
Parametrised multi-LED hue-cycling PWM engine; successor to the single fixed RGB colour-wheel driver.
- Steps a hue counter around a 6-sector colour wheel.
- Converts hue to R/G/B duty, scales by a brightness byte, and drives NUM_LEDS RGB outputs with evenly spaced hue offsets.
- Sits between top-level mode/brightness controls and the RGB pads.

Parameters:
PWM_INTERVAL, 1200, clocks per PWM period (>=2)
STEP_PERIODS, 100, PWM periods per hue step (>=1)
HUE_STEPS, 360, hue positions per revolution; must be a multiple of 6
NUM_LEDS, 1, number of RGB LEDs; LED i hue offset = i*(HUE_STEPS/NUM_LEDS)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  run enable; low freezes counters and forces outputs low
mode  in  2  0 forward, 1 reverse, 2 hold, 3 manual step
step_req  in  1  manual step request (mode 3 only)
brightness  in  8  global brightness; 0 = off
pwm_r  out  NUM_LEDS  red PWM per LED
pwm_g  out  NUM_LEDS  green PWM per LED
pwm_b  out  NUM_LEDS  blue PWM per LED
hue  out  $clog2(HUE_STEPS)  current base hue (LED 0)
period_start  out  1  one-cycle pulse, first cycle of each PWM period
wrap  out  1  one-cycle pulse on hue wrap-around

Behaviour:
- Reset (async assert, sync release): pwm_cnt=0, step_cnt=0, hue=0, all latched duties=0, step pending=0; all outputs 0.
- pwm_cnt counts 0..PWM_INTERVAL-1 and wraps. period_start is registered: high in the cycle after pwm_cnt==PWM_INTERVAL-1, and in the first enabled cycle after reset.
- Step boundary: cycle where pwm_cnt==PWM_INTERVAL-1 and step_cnt==STEP_PERIODS-1. step_cnt increments on each period end and wraps there.
- Hue update at a step boundary:
  - mode 0: hue+1, HUE_STEPS-1 -> 0.
  - mode 1: hue-1, 0 -> HUE_STEPS-1.
  - mode 2: unchanged.
  - mode 3: hue+1 only if a step is pending, then pending clears. Any step_req pulse since the last boundary sets pending; multiple pulses collapse to one step.
- wrap: pulses in the cycle after a hue wrap in either direction.
- mode changes apply at the next step boundary; step_cnt is not cleared by a mode change.
- Duty: S = HUE_STEPS/6, sector = h/S, f = h%S, M = PWM_INTERVAL, up = (f*M)/S (truncating), dn = M-up.
  - Sector 0: R=M, G=up, B=0
  - Sector 1: R=dn, G=M, B=0
  - Sector 2: R=0, G=M, B=up
  - Sector 3: R=0, G=dn, B=M
  - Sector 4: R=up, G=0, B=M
  - Sector 5: R=M, G=0, B=dn
- Per-LED hue: (hue + i*(HUE_STEPS/NUM_LEDS)) mod HUE_STEPS; the offset is constant at elaboration.
- Scaling: brightness==0 gives duty 0; otherwise (duty*(brightness+1))>>8.
  - Product width = duty width + 9 bits; no overflow.
- Scaled duties are latched at pwm_cnt==PWM_INTERVAL-1, using the hue value after any update in that same cycle. Duty changes only at period boundaries, so there are no mid-period glitches.
- Output: registered, 1-cycle latency. pwm_x[i](t+1) = en(t) & (pwm_cnt(t) < duty_lat_x[i](t)).
  - Duty M gives constant high; duty 0 gives constant low.
- The first period after reset outputs all low (latched duty 0). Hue-0 duties apply from the second period.
- en=0: pwm_cnt, step_cnt, hue and pending all hold; outputs 0 next cycle; no pulses. Resuming continues from the held counts.
- rst mid-period: outputs drop to 0 immediately (asynchronously).

Optional Feature:
HUE_PWM_INVERT_EN
- Defined: pwm_r/g/b are active-low for common-anode pads. Reset and en=0 value is all 1s; the duty comparison result is inverted.
- Undefined: outputs are active-high as specified above.
- period_start, wrap and hue are unaffected in both cases.

Test Plan:
Params PWM_INTERVAL=12, STEP_PERIODS=2, HUE_STEPS=12, NUM_LEDS=2, brightness=255, en=1, mode=0 unless stated.
- Reset release -> period 1 all outputs low. Period 2: LED0 R high 12/12, G=B=0. LED1 (hue 6) R=0, G=12/12, B=12/12.
- Run 2 periods -> hue=1. Next period LED0 R=12, G high for first 6 cycles, B=0. period_start every 12 clocks.
- brightness=127 at hue 0 -> LED0 R high for 6 of 12 cycles, effective from the period after the latch.
- mode=1 from hue 0 -> at the boundary hue=11 and wrap pulses once. Next period LED0 R=12, G=0, B=6.
- mode=3 with 3 step_req pulses in one step interval -> hue advances exactly 1 at the boundary. No pulses -> no change.
- en=0 mid-period for 20 cycles -> outputs 0 and counters frozen, then resume from the same pwm_cnt. Async rst mid-period -> outputs 0 before the next clk edge and hue=0.
